// File: rtl/envelope_averager_if.sv
// ---------------------------------------------------------------------------
// envelope_averager_if
//
// Purpose:
//   Groups the sample stream and the envelope result of envelope_averager
//   into one bundle. The same bundle carries the FSM state for observation.
//
// Handshake:
//   sample_in is taken on every rising edge where sample_valid is high. There
//   is no ready signal, so the consumer can never stall the producer. clear is
//   sampled on the same edges and wins over sample_valid. env_valid is a
//   single-cycle pulse that marks a new env_avg value. env_avg holds its value
//   between pulses.
//
// Signals:
//   sample_in    [SAMPLE_WIDTH-1:0]  signed audio sample (master -> slave)
//   sample_valid                     sample strobe       (master -> slave)
//   clear                            restart averaging   (master -> slave)
//   env_avg      [SAMPLE_WIDTH-1:0]  mean magnitude      (slave -> master)
//   env_valid                        env_avg update pulse(slave -> master)
//   env_primed                       a window completed  (slave -> master)
//   fsm_state    [0:0]               FSM state, 0 = WARMUP, 1 = RUN
// ---------------------------------------------------------------------------
interface envelope_averager_if #(
   parameter int SAMPLE_WIDTH = 24
);
   logic [SAMPLE_WIDTH-1:0] sample_in;
   logic                    sample_valid;
   logic                    clear;
   logic [SAMPLE_WIDTH-1:0] env_avg;
   logic                    env_valid;
   logic                    env_primed;
   logic [0:0]              fsm_state;

   // Sample source side.
   modport master (
      output sample_in,
      output sample_valid,
      output clear,
      input  env_avg,
      input  env_valid,
      input  env_primed,
      input  fsm_state
   );

   // Averager side.
   modport slave (
      input  sample_in,
      input  sample_valid,
      input  clear,
      output env_avg,
      output env_valid,
      output env_primed,
      output fsm_state
   );
endinterface

// File: rtl/envelope_averager.sv
// ---------------------------------------------------------------------------
// envelope_averager
//
// Purpose:
//   Full-wave rectifies a signed audio stream and produces the mean magnitude
//   over consecutive, non-overlapping windows of 2^LOG2_WINDOW accepted
//   samples. The result feeds the envelope input of the cutoff-frequency unit.
//
// Parameters:
//   SAMPLE_WIDTH  width of samples and of env_avg (default 24)
//   LOG2_WINDOW   window length is 2^LOG2_WINDOW samples, legal 1..12
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   envelope_averager_if.slave: sample_in, sample_valid, clear in;
//         env_avg, env_valid, env_primed, fsm_state out
//
// Behaviour:
//   - The magnitude of the most negative sample saturates to the most
//     positive value, so every rectified sample fits in SAMPLE_WIDTH-1 bits.
//   - The accumulator is SAMPLE_WIDTH+LOG2_WINDOW bits; the largest possible
//     window sum is below 2^(SAMPLE_WIDTH-1+LOG2_WINDOW), so it cannot wrap.
//   - When the last sample of a window is accepted, env_avg takes the
//     truncated mean on that same edge and env_valid pulses for one cycle.
//   - Idle cycles (sample_valid low) freeze all state.
//   - clear zeroes everything and returns to WARMUP; a sample presented on
//     the same edge is dropped.
//   - Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module envelope_averager #(
   parameter int SAMPLE_WIDTH = 24,
   parameter int LOG2_WINDOW  = 8
) (
   input logic                 clk,
   input logic                 rst,
   envelope_averager_if.slave  bus
);

   localparam int ACC_WIDTH = SAMPLE_WIDTH + LOG2_WINDOW;

   // FSM encoding: WARMUP until the first window completes, then RUN.
   localparam logic [0:0] WARMUP = 1'b0;
   localparam logic [0:0] RUN    = 1'b1;

   localparam logic [SAMPLE_WIDTH-1:0] MOST_NEG = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
   localparam logic [SAMPLE_WIDTH-1:0] MOST_POS = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

   logic [0:0]              state;
   logic [ACC_WIDTH-1:0]    acc;
   logic [LOG2_WINDOW-1:0]  count;
   logic [SAMPLE_WIDTH-1:0] avg_q;
   logic                    valid_q;

   logic [SAMPLE_WIDTH-1:0] rect;
   logic [ACC_WIDTH-1:0]    sum;
   logic                    window_done;

   // ------------------------------------------------------------------------
   // Rectifier. Negating MOST_NEG in two's complement gives MOST_NEG again,
   // so that one code is caught explicitly and clamped.
   // ------------------------------------------------------------------------
   always_comb begin
      rect = bus.sample_in;
      if (bus.sample_in == MOST_NEG) begin
         rect = MOST_POS;
      end else if (bus.sample_in[SAMPLE_WIDTH-1]) begin
         rect = ~bus.sample_in + 1'b1;
      end
   end

   // Running sum including the sample on the input right now. On the final
   // sample of a window this is the complete window total.
   always_comb begin
      sum         = acc + {{LOG2_WINDOW{1'b0}}, rect};
      window_done = bus.sample_valid && (count == {LOG2_WINDOW{1'b1}});
   end

   // ------------------------------------------------------------------------
   // Datapath and FSM. clear takes priority over a sample on the same edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= WARMUP;
         acc     <= '0;
         count   <= '0;
         avg_q   <= '0;
         valid_q <= 1'b0;
      end else if (bus.clear) begin
         state   <= WARMUP;
         acc     <= '0;
         count   <= '0;
         avg_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (bus.sample_valid) begin
            // The counter is exactly LOG2_WINDOW bits, so it wraps to 0 on
            // its own after the last sample of the window.
            count <= count + 1'b1;
            if (window_done) begin
               // Dropping the low LOG2_WINDOW bits divides by the window
               // length with truncation.
               avg_q   <= sum[ACC_WIDTH-1:LOG2_WINDOW];
               valid_q <= 1'b1;
               acc     <= '0;
               state   <= RUN;
            end else begin
               acc <= sum;
            end
         end
      end
   end

   assign bus.env_avg    = avg_q;
   assign bus.env_valid  = valid_q;
   // env_primed is the RUN state bit itself.
   assign bus.env_primed = (state == RUN);
   assign bus.fsm_state  = state;

endmodule

// File: tb/tb_envelope_averager.sv
// ---------------------------------------------------------------------------
// tb_envelope_averager
//
// Bench for envelope_averager with a 4-sample window. Expected averages come
// from a window model that keeps the magnitudes of the current window in a
// queue; each completed window pushes its mean onto exp_q, and a monitor pops
// and compares on every env_valid pulse.
// ---------------------------------------------------------------------------
module tb_envelope_averager;

  localparam int W = 24;
  localparam int L = 2;
  localparam int WIN = 1 << L;
  localparam int MAX_POS = (1 << (W - 1)) - 1;

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  int           win_q[$];
  logic         model_primed;
  logic [W-1:0] model_avg;

  envelope_averager_if #(.SAMPLE_WIDTH(W)) bus ();

  envelope_averager #(
    .SAMPLE_WIDTH(W),
    .LOG2_WINDOW (L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    #5;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_accept(input logic [W-1:0] s);
    int v;
    int mag;
    longint total;
    v   = int'($signed(s));
    mag = (v < 0) ? -v : v;
    if (mag > MAX_POS) mag = MAX_POS;
    win_q.push_back(mag);
    if (win_q.size() == WIN) begin
      total = 0;
      foreach (win_q[i]) total += win_q[i];
      model_avg = W'(total / WIN);
      exp_q.push_back(model_avg);
      model_primed = 1'b1;
      win_q.delete();
    end
  endfunction

  function automatic void model_restart();
    win_q.delete();
    model_primed = 1'b0;
    model_avg    = '0;
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; state checks are made there too.
  task automatic send(input logic [W-1:0] s);
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    model_accept(s);
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = $urandom();
    check("primed", bus.env_primed, model_primed);
    check("avg_after_sample", bus.env_avg, model_avg);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("avg_hold", bus.env_avg, model_avg);
    end
  endtask

  task automatic clear_with(input logic [W-1:0] s);
    bus.clear        = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = s;
    model_restart();
    @(posedge clk);
    #1;
    bus.clear        = 1'b0;
    bus.sample_valid = 1'b0;
    check("clear_primed", bus.env_primed, 1'b0);
    check("clear_state", bus.fsm_state, 1'b0);
    check("clear_avg", bus.env_avg, '0);
    check("clear_valid", bus.env_valid, 1'b0);
  endtask

  task automatic drained(input string name);
    idle(2);
    check(name, exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int pulses = 0;
  always @(negedge clk) begin
    if (!rst && bus.env_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_env_valid: got avg %0h expected no pulse at %0t", bus.env_avg, $time);
      end else begin
        check("env_avg", bus.env_avg, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  int p0;
  initial begin
    rst              = 1'b0;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.clear        = 1'b0;
    model_restart();

    // Reset with no clock edge yet.
    #1 rst = 1'b1;
    #1;
    check("reset_avg", bus.env_avg, '0);
    check("reset_valid", bus.env_valid, 1'b0);
    check("reset_primed", bus.env_primed, 1'b0);
    check("reset_state", bus.fsm_state, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic window: mean of 100,200,300,400 = 250.
    p0 = pulses;
    send(24'd100);
    send(-24'sd200);
    send(24'd300);
    send(-24'sd400);
    check("basic_avg", bus.env_avg, 24'd250);
    check("basic_valid", bus.env_valid, 1'b1);
    idle(1);
    check("basic_valid_drop", bus.env_valid, 1'b0);
    check("basic_primed", bus.env_primed, 1'b1);
    check("basic_pulses", pulses - p0, 1);

    // Saturation then truncation.
    repeat (4) send(24'h800000);
    check("sat_avg", bus.env_avg, 24'h7FFFFF);
    send(24'd1); send(24'd1); send(24'd1); send(24'd0);
    check("trunc_avg", bus.env_avg, 24'd0);
    drained("sat_drained");

    // Gapped input.
    p0 = pulses;
    repeat (4) begin
      send(24'd8);
      idle(3);
    end
    check("gap_avg", bus.env_avg, 24'd8);
    check("gap_pulses", pulses - p0, 1);

    // Clear mid-window with a colliding sample.
    send(24'd1000);
    send(24'd1000);
    clear_with(24'd5000);
    repeat (4) send(24'd8);
    check("after_clear_avg", bus.env_avg, 24'd8);
    check("after_clear_primed", bus.env_primed, 1'b1);
    drained("clear_drained");

    // Async reset between edges, mid-window.
    send(24'd500);
    send(24'd700);
    rst = 1'b1;
    #2;
    check("async_avg", bus.env_avg, '0);
    check("async_valid", bus.env_valid, 1'b0);
    check("async_primed", bus.env_primed, 1'b0);
    rst = 1'b0;
    model_restart();
    repeat (4) send(24'd16);
    check("async_after_avg", bus.env_avg, 24'd16);
    drained("async_drained");

    // Randomized traffic with gaps, extreme values and occasional clears.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] s;
      case ($urandom_range(0, 9))
        0:       s = 24'h800000;
        1:       s = 24'h7FFFFF;
        2:       s = W'($urandom_range(0, 3));
        default: s = W'($urandom());
      endcase
      if ($urandom_range(0, 39) == 0) clear_with(s);
      else send(s);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    drained("random_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/envelope_averager.md
ENVELOPE_AVERAGER -- requirements
Module: envelope_averager

Interface
REQ-001 The block SHALL have parameter SAMPLE_WIDTH, default 24, giving the width of audio samples and of the envelope output.
REQ-002 The block SHALL have parameter LOG2_WINDOW, default 8, giving the averaging window as 2^LOG2_WINDOW accepted samples; the legal range is 1..12.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1 bit: sole clock, rising-edge active.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port sample_in, input, SAMPLE_WIDTH bits: signed two's-complement audio sample.
REQ-007 Port sample_valid, input, 1 bit: sample_in is accepted on any rising edge where this is high; no backpressure.
REQ-008 Port clear, input, 1 bit: synchronous restart of averaging.
REQ-009 Port env_avg, output, SAMPLE_WIDTH bits: unsigned mean magnitude of the last completed window; this is the envelope input of the cutoff-frequency unit.
REQ-010 Port env_valid, output, 1 bit: one-cycle pulse marking an env_avg update.
REQ-011 Port env_primed, output, 1 bit: high once at least one window has completed since reset or clear.

Function
REQ-012 Rectification SHALL be |sample_in|; the most negative value (e.g. 0x800000) SHALL saturate to the most positive (0x7FFFFF).
REQ-013 The accumulator SHALL be SAMPLE_WIDTH+LOG2_WINDOW bits wide, unsigned, and SHALL never overflow.
REQ-014 The sample counter SHALL be LOG2_WINDOW bits wide and SHALL increment once per accepted sample, wrapping from 2^LOG2_WINDOW-1 to 0.
REQ-015 A two-state FSM SHALL be used: WARMUP (no window completed) and RUN; env_primed SHALL be 1 exactly in RUN.
REQ-016 Transitions: WARMUP->RUN on the first window completion; RUN->WARMUP on clear; reset enters WARMUP.
REQ-017 Window completion SHALL occur on the edge that accepts a sample while the counter equals 2^LOG2_WINDOW-1.
REQ-018 On window completion, env_avg SHALL register (accumulator + rectified sample) >> LOG2_WINDOW (truncating), env_valid SHALL be 1 for exactly the following cycle, and the accumulator SHALL restart at 0.
REQ-019 Latency SHALL be one clock: env_avg and env_valid are visible directly after the edge that accepts the final sample of the window.
REQ-020 env_avg SHALL hold its value between completions; it SHALL not change while sample_valid is low.
REQ-021 Gaps in sample_valid of any length SHALL not affect the result; the accumulator and counter SHALL hold.
REQ-022 clear high on an edge SHALL zero the accumulator, the counter, env_avg, env_valid, and env_primed, and SHALL enter WARMUP.
REQ-023 clear and sample_valid high on the same edge: clear SHALL win and the sample SHALL be discarded.
REQ-024 All outputs SHALL be driven directly from registers.

Reset
REQ-025 While rst is high, the accumulator, counter, env_avg, env_valid, and env_primed SHALL be 0 and the FSM SHALL be in WARMUP, taking effect immediately without a clock.
REQ-026 Deasserting rst mid-window SHALL discard all partial-window samples; the first accepted sample after reset SHALL be sample 0 of a new window.

Verification (bench overrides LOG2_WINDOW=2, window = 4)
REQ-027 Reset check: assert rst with no clock -> env_avg=0, env_valid=0, env_primed=0.
REQ-028 Basic window: samples 100, -200, 300, -400 on consecutive cycles -> env_avg=250 and env_valid high for exactly one cycle after the 4th edge, env_primed=1 thereafter.
REQ-029 Saturation and truncation: four samples of 0x800000 -> env_avg=0x7FFFFF; then samples 1, 1, 1, 0 -> env_avg=0.
REQ-030 Gapped input: samples 8, 8, 8, 8 with 3 idle cycles between each -> env_avg=8, exactly one env_valid pulse, and env_avg stable during the gaps.
REQ-031 Clear mid-window: samples 1000 and 1000, then clear together with sample 5000, then 8, 8, 8, 8 -> env_primed=0 after clear, then env_avg=8 and env_primed=1.
REQ-032 Async reset mid-window: after 2 samples, pulse rst between edges -> outputs go to 0 before the next edge; the next 4 samples of 16 -> env_avg=16.
